uart_tx_interface: RTL and testbench
====================================

Name: uart_tx_interface

Overview:
Return path of the UART/ALU link. Accepts ALU results over a valid-pulse interface and serialises each one into a 3-byte response frame (HEADER, RESULT, CHECKSUM). Bytes go to the UART transmitter through a start/done byte handshake. Sits between the ALU output and the UART TX core, and mirrors the command parser on the RX side.

Parameters:
NB_DATA, 8, byte and result width
HEADER, 8'hA5, frame start byte
NB_TIMEOUT, 16, width of the per-byte watchdog counter
TIMEOUT, 16'd50000, max clk cycles to wait for i_tx_done per byte

Ports:
clk  in  1  system clock
i_rst_n  in  1  reset, asynchronous, active-low
i_result  in  NB_DATA  ALU result
i_result_valid  in  1  1-cycle pulse, i_result valid
i_tx_done  in  1  1-cycle pulse from UART TX, current byte fully sent
o_tx_data  out  NB_DATA  byte to transmit, stable from start until done
o_tx_start  out  1  1-cycle pulse, launch byte
o_busy  out  1  high when state != IDLE
o_overrun  out  1  1-cycle pulse, a result was dropped
o_timeout  out  1  1-cycle pulse, frame aborted by watchdog

Behaviour:
- Reset (async, any time, including mid-frame): state=IDLE, pending_full=0, pending=0, frame=0, counter=0; all outputs 0. The frame in flight is discarded with no further start pulses.
- Holding register (1 entry), updated at each edge:
  - i_result_valid with pending empty: pending<=i_result, pending_full<=1.
  - i_result_valid while pending is consumed in the same edge: the new value is accepted (consume has priority, then refill).
  - i_result_valid with pending full and not consumed: the new value is dropped; o_overrun=1 for the next cycle.
- FSM states: IDLE, WAIT_HDR, WAIT_DATA, WAIT_CHK. o_tx_data and o_tx_start are registered.
  - IDLE and pending_full: frame<=pending, consume pending, o_tx_data<=HEADER, o_tx_start<=1, go to WAIT_HDR.
  - WAIT_HDR and i_tx_done: o_tx_data<=frame, start, go to WAIT_DATA.
  - WAIT_DATA and i_tx_done: o_tx_data<=HEADER ^ frame, start, go to WAIT_CHK.
  - WAIT_CHK and i_tx_done: if pending_full, begin the next frame exactly as from IDLE (back-to-back, no idle cycle); else go to IDLE and clear o_tx_data to 0.
- o_tx_start is high for exactly one cycle per byte and is cleared on the following edge.
- i_tx_done is ignored in IDLE and in any cycle where o_tx_start=1.
- Latency: i_result_valid sampled at edge k, FSM idle → o_tx_start=1 and o_tx_data=HEADER after edge k+1.
- Watchdog:
  - Counter clears on every start and increments each cycle in a WAIT state.
  - Reaching TIMEOUT without i_tx_done: o_timeout=1 for one cycle, go to IDLE, o_tx_data<=0.
  - pending is kept and is sent as a fresh frame on the next edge.
  - i_tx_done on the same edge as expiry wins: the transition proceeds and there is no timeout.
- Checksum: bitwise XOR over NB_DATA bits, no carry.
- o_busy is a combinational decode of the registered state.

Decomposition:
- Shared package uart_pkg: state encoding localparams (IDLE, WAIT_HDR, WAIT_DATA, WAIT_CHK), default HEADER value, NB_DATA default. The RX parser uses the same header constant.
- No sub-module required; holding register, FSM and watchdog fit in one module. The UART TX core is instantiated by the parent, not here.

Test Plan:
1. Reset, then i_result=8'h3C pulse. Respond with done 10 cycles after each start → bytes A5, 3C, 99. Exactly 3 start pulses; o_busy falls after the third done; first start lands one edge after valid is sampled.
2. i_result=8'h00 → bytes A5, 00, A5; o_overrun and o_timeout stay 0.
3. Send 8'h12, then pulse 8'h34 during WAIT_DATA → frame A5,12,B7 then A5,34,91 with no idle cycle between the CHK done and the next start; o_overrun=0.
4. During a frame pulse 8'h55 then 8'h66 (pending already full) → 8'h66 dropped with one o_overrun pulse; the next frame is A5,55,F0.
5. TIMEOUT=8, never assert done → o_timeout pulses 8 cycles after the first start and FSM returns to IDLE. With a result pending, a new HEADER start follows on the next edge.
6. Assert i_rst_n=0 in WAIT_DATA → all outputs 0 immediately (async). After release there are no start pulses until a new i_result_valid.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART/ALU link (TX response framer and RX command parser).
//   NB_DATA_DEF : default byte/result width
//   HEADER_DEF  : frame start byte, identical on both directions of the link
//   tx_state_e  : response framer states
package uart_pkg;

   localparam int unsigned NB_DATA_DEF = 8;
   localparam logic [NB_DATA_DEF-1:0] HEADER_DEF = 8'hA5;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_HDR,
      WAIT_DATA,
      WAIT_CHK
   } tx_state_e;

endpackage

// File: rtl/uart_tx_interface.sv
// UART response framer: turns each ALU result into a 3-byte frame
// (HEADER, RESULT, HEADER ^ RESULT) and feeds it byte by byte to the UART TX core.
// Ports:
//   clk            : system clock
//   i_rst_n        : asynchronous active-low reset
//   i_result       : ALU result
//   i_result_valid : 1-cycle pulse, i_result valid
//   i_tx_done      : 1-cycle pulse from TX core, current byte sent
//   o_tx_data      : byte to transmit, stable from start until done
//   o_tx_start     : 1-cycle pulse launching o_tx_data
//   o_busy         : framer not idle
//   o_overrun      : 1-cycle pulse, a result was dropped
//   o_timeout      : 1-cycle pulse, frame aborted by the per-byte watchdog
module uart_tx_interface
   import uart_pkg::*;
#(
   parameter int unsigned             NB_DATA    = NB_DATA_DEF,
   parameter logic [NB_DATA-1:0]      HEADER     = HEADER_DEF,
   parameter int unsigned             NB_TIMEOUT = 16,
   parameter logic [NB_TIMEOUT-1:0]   TIMEOUT    = 16'd50000
) (
   input  logic               clk,
   input  logic               i_rst_n,
   input  logic [NB_DATA-1:0] i_result,
   input  logic               i_result_valid,
   input  logic               i_tx_done,
   output logic [NB_DATA-1:0] o_tx_data,
   output logic               o_tx_start,
   output logic               o_busy,
   output logic               o_overrun,
   output logic               o_timeout
);

   // Counter value seen on the edge where the watchdog would reach TIMEOUT.
   localparam logic [NB_TIMEOUT-1:0] TO_LAST = TIMEOUT - NB_TIMEOUT'(1);

   tx_state_e              state_q, state_d;
   logic [NB_DATA-1:0]     pending_q, pending_d;
   logic                   pending_full_q, pending_full_d;
   logic [NB_DATA-1:0]     frame_q, frame_d;
   logic [NB_TIMEOUT-1:0]  cnt_q, cnt_d;
   logic [NB_DATA-1:0]     tx_data_q, tx_data_d;
   logic                   tx_start_q, tx_start_d;
   logic                   overrun_q, overrun_d;
   logic                   timeout_q, timeout_d;

   logic                   done_eff;
   logic                   expired;
   logic                   launch;
   logic                   abort;

   // A done arriving while start is still high belongs to no launched byte.
   assign done_eff = i_tx_done & ~tx_start_q;
   assign expired  = (cnt_q == TO_LAST);

   always_ff @(posedge clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q        <= IDLE;
         pending_q      <= '0;
         pending_full_q <= 1'b0;
         frame_q        <= '0;
         cnt_q          <= '0;
         tx_data_q      <= '0;
         tx_start_q     <= 1'b0;
         overrun_q      <= 1'b0;
         timeout_q      <= 1'b0;
      end else begin
         state_q        <= state_d;
         pending_q      <= pending_d;
         pending_full_q <= pending_full_d;
         frame_q        <= frame_d;
         cnt_q          <= cnt_d;
         tx_data_q      <= tx_data_d;
         tx_start_q     <= tx_start_d;
         overrun_q      <= overrun_d;
         timeout_q      <= timeout_d;
      end
   end

   always_comb begin
      state_d        = state_q;
      pending_d      = pending_q;
      pending_full_d = pending_full_q;
      frame_d        = frame_q;
      cnt_d          = cnt_q;
      tx_data_d      = tx_data_q;
      tx_start_d     = 1'b0;
      overrun_d      = 1'b0;
      timeout_d      = 1'b0;
      launch         = 1'b0;
      abort          = 1'b0;

      case (state_q)
         IDLE: begin
            cnt_d  = '0;
            launch = pending_full_q;
         end
         WAIT_HDR: begin
            if (done_eff) begin
               tx_data_d  = frame_q;
               tx_start_d = 1'b1;
               cnt_d      = '0;
               state_d    = WAIT_DATA;
            end else if (expired) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_q + NB_TIMEOUT'(1);
            end
         end
         WAIT_DATA: begin
            if (done_eff) begin
               tx_data_d  = HEADER ^ frame_q;
               tx_start_d = 1'b1;
               cnt_d      = '0;
               state_d    = WAIT_CHK;
            end else if (expired) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_q + NB_TIMEOUT'(1);
            end
         end
         WAIT_CHK: begin
            if (done_eff) begin
               if (pending_full_q) begin
                  launch = 1'b1;
               end else begin
                  tx_data_d = '0;
                  cnt_d     = '0;
                  state_d   = IDLE;
               end
            end else if (expired) begin
               abort = 1'b1;
            end else begin
               cnt_d = cnt_q + NB_TIMEOUT'(1);
            end
         end
         default: state_d = IDLE;
      endcase

      // Frame launch is shared by IDLE and the back-to-back path out of WAIT_CHK.
      if (launch) begin
         frame_d    = pending_q;
         tx_data_d  = HEADER;
         tx_start_d = 1'b1;
         cnt_d      = '0;
         state_d    = WAIT_HDR;
      end

      // Watchdog abort keeps the holding register; IDLE relaunches it next edge.
      if (abort) begin
         timeout_d = 1'b1;
         tx_data_d = '0;
         cnt_d     = '0;
         state_d   = IDLE;
      end

      // Consume takes effect first, so a result arriving on that edge refills.
      if (i_result_valid) begin
         if (!pending_full_q || launch) begin
            pending_d      = i_result;
            pending_full_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end else if (launch) begin
         pending_full_d = 1'b0;
      end
   end

   assign o_tx_data  = tx_data_q;
   assign o_tx_start = tx_start_q;
   assign o_busy     = (state_q != IDLE);
   assign o_overrun  = overrun_q;
   assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_interface.sv
// Bench for uart_tx_interface: directed scenarios plus randomized result streams,
// checked against a frame-level model (one holding slot, fixed TX byte time).
module tb_uart_tx_interface;

   localparam logic [7:0] HDR = 8'hA5;

   logic       clk;
   logic       rst_n;
   logic [7:0] result, result_b;
   logic       valid, valid_b;
   logic       done, done_b;
   logic [7:0] tx_data, tx_data_b;
   logic       tx_start, tx_start_b;
   logic       busy, busy_b;
   logic       overrun, overrun_b;
   logic       timeout, timeout_b;

   int checks = 0;
   int errors = 0;

   // Observed traffic (main instance)
   logic [7:0] got_q[$];
   int         start_edge_q[$];
   int         starts_seen   = 0;
   int         got_overrun   = 0;
   int         got_timeout   = 0;
   int         got_timeout_b = 0;

   // Reference model state
   logic [7:0] exp_q[$];
   int         m_edge      = 0;
   logic       m_full      = 1'b0;
   logic [7:0] m_slot      = 8'h00;
   int         m_link_free = 0;
   int         exp_overrun = 0;

   int resp_delay = 10;
   int resp_cnt   = 0;

   uart_tx_interface dut (
      .clk            (clk),
      .i_rst_n        (rst_n),
      .i_result       (result),
      .i_result_valid (valid),
      .i_tx_done      (done),
      .o_tx_data      (tx_data),
      .o_tx_start     (tx_start),
      .o_busy         (busy),
      .o_overrun      (overrun),
      .o_timeout      (timeout)
   );

   uart_tx_interface #(.TIMEOUT(16'd8)) dut_to (
      .clk            (clk),
      .i_rst_n        (rst_n),
      .i_result       (result_b),
      .i_result_valid (valid_b),
      .i_tx_done      (done_b),
      .o_tx_data      (tx_data_b),
      .o_tx_start     (tx_start_b),
      .o_busy         (busy_b),
      .o_overrun      (overrun_b),
      .o_timeout      (timeout_b)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #900000;
      $display("FAIL global_time_limit: simulation did not finish in time");
      $fatal(1, "time limit");
   end

   // Model: a result waits in one slot; a frame starts on the first edge where the
   // slot is full and the link is free; a frame holds the link for 3 byte times.
   initial begin
      forever begin
         @(posedge clk);
         m_edge++;
         if (!rst_n) begin
            m_full      = 1'b0;
            m_link_free = 0;
         end else begin
            if (m_full && m_edge >= m_link_free) begin
               exp_q.push_back(HDR);
               exp_q.push_back(m_slot);
               exp_q.push_back(HDR ^ m_slot);
               m_link_free = m_edge + 3 * resp_delay;
               m_full      = 1'b0;
            end
            if (valid) begin
               if (!m_full) begin
                  m_slot = result;
                  m_full = 1'b1;
               end else begin
                  exp_overrun++;
               end
            end
         end
      end
   end

   // Output monitor
   initial begin
      forever begin
         @(negedge clk);
         if (tx_start) begin
            got_q.push_back(tx_data);
            start_edge_q.push_back(m_edge);
            starts_seen++;
         end
         if (overrun)   got_overrun++;
         if (timeout)   got_timeout++;
         if (timeout_b) got_timeout_b++;
      end
   end

   // TX core stand-in: done is sampled resp_delay edges after the start edge
   initial begin
      done = 1'b0;
      forever begin
         @(negedge clk);
         done = 1'b0;
         if (!rst_n) begin
            resp_cnt = 0;
         end else if (tx_start) begin
            resp_cnt = resp_delay;
         end else if (resp_cnt > 0) begin
            resp_cnt--;
            if (resp_cnt == 1) done = 1'b1;
         end
      end
   end

   task automatic step();
      @(negedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic pulse(input logic [7:0] v);
      result = v;
      valid  = 1'b1;
      step();
      valid  = 1'b0;
   endtask

   task automatic wait_starts(input int n);
      int budget = 400;
      while (starts_seen < n && budget > 0) begin
         step();
         budget--;
      end
      chk("wait_starts", (budget > 0), 1);
   endtask

   task automatic wait_idle();
      int budget = 4000;
      while (!(!busy && !m_full && m_edge > m_link_free) && budget > 0) begin
         step();
         budget--;
      end
      chk("wait_idle", (budget > 0), 1);
   endtask

   task automatic compare_frames();
      chk("frame_len", got_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++) begin
         chk($sformatf("frame_byte[%0d]", i), got_q[i], exp_q[i]);
      end
      chk("overrun_count", got_overrun, exp_overrun);
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      int base;
      int base_ov;
      int budget;

      rst_n    = 1'b0;
      valid    = 1'b0;
      result   = 8'h00;
      valid_b  = 1'b0;
      result_b = 8'h00;
      done_b   = 1'b0;
      repeat (3) step();

      chk("rst_tx_data",  tx_data,  0);
      chk("rst_tx_start", tx_start, 0);
      chk("rst_busy",     busy,     0);
      chk("rst_overrun",  overrun,  0);
      chk("rst_timeout",  timeout,  0);
      rst_n = 1'b1;
      step();

      // 1: single frame, latency and busy release
      base = starts_seen;
      pulse(8'h3C);
      step();
      chk("t1_latency_start", tx_start, 1);
      chk("t1_latency_hdr",   tx_data,  HDR);
      wait_starts(base + 3);
      for (int i = 0; i < resp_delay - 1; i++) begin
         step();
         chk("t1_busy_hold", busy, 1);
      end
      step();
      chk("t1_busy_fall", busy, 0);
      wait_idle();
      chk("t1_start_count", starts_seen - base, 3);
      chk("t1_byte2", got_q[2], 8'h99);
      compare_frames();

      // 2: zero result
      base_ov = got_overrun;
      pulse(8'h00);
      wait_idle();
      chk("t2_byte2", got_q[2], 8'hA5);
      chk("t2_overrun", got_overrun - base_ov, 0);
      chk("t2_timeout", got_timeout, 0);
      compare_frames();

      // 3: result arriving mid-frame is sent back-to-back
      base    = starts_seen;
      base_ov = got_overrun;
      pulse(8'h12);
      wait_starts(base + 2);
      repeat (3) step();
      pulse(8'h34);
      wait_idle();
      chk("t3_back_to_back", start_edge_q[base + 3] - start_edge_q[base + 2], resp_delay);
      chk("t3_chk1", got_q[2], 8'hB7);
      chk("t3_chk2", got_q[5], 8'h91);
      chk("t3_overrun", got_overrun - base_ov, 0);
      compare_frames();

      // 4: second result while slot full is dropped
      base    = starts_seen;
      base_ov = got_overrun;
      pulse(8'h77);
      wait_starts(base + 1);
      step();
      pulse(8'h55);
      pulse(8'h66);
      wait_idle();
      chk("t4_overrun_pulses", got_overrun - base_ov, 1);
      chk("t4_len", got_q.size(), 6);
      chk("t4_hdr",  got_q[3], 8'hA5);
      chk("t4_data", got_q[4], 8'h55);
      chk("t4_chk",  got_q[5], 8'hF0);
      compare_frames();

      // 5: watchdog on the TIMEOUT=8 instance, done never arrives
      result_b = 8'h5A;
      valid_b  = 1'b1;
      step();
      valid_b  = 1'b0;
      step();
      chk("t5_start", tx_start_b, 1);
      chk("t5_hdr",   tx_data_b,  HDR);
      result_b = 8'h6E;
      valid_b  = 1'b1;
      step();
      valid_b  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("t5_no_early_timeout", timeout_b, 0);
         chk("t5_busy", busy_b, 1);
      end
      step();
      chk("t5_timeout", timeout_b, 1);
      chk("t5_idle", busy_b, 0);
      chk("t5_data_clr", tx_data_b, 0);
      step();
      chk("t5_restart", tx_start_b, 1);
      chk("t5_restart_hdr", tx_data_b, HDR);
      chk("t5_timeout_once", timeout_b, 0);
      budget = 20;
      while (got_timeout_b < 2 && budget > 0) begin
         step();
         budget--;
      end
      chk("t5_second_timeout", got_timeout_b, 2);
      step();
      chk("t5_final_idle", busy_b, 0);
      chk("t5_no_overrun", overrun_b, 0);

      // 6: asynchronous reset in WAIT_DATA
      base = starts_seen;
      pulse(8'h4D);
      wait_starts(base + 2);
      repeat (4) step();
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_tx_data",  tx_data,  0);
      chk("t6_tx_start", tx_start, 0);
      chk("t6_busy",     busy,     0);
      chk("t6_overrun",  overrun,  0);
      chk("t6_timeout",  timeout,  0);
      step();
      step();
      rst_n = 1'b1;
      got_q.delete();
      exp_q.delete();
      base = starts_seen;
      repeat (40) step();
      chk("t6_no_starts", starts_seen - base, 0);
      pulse(8'hC3);
      wait_idle();
      compare_frames();

      // Randomized result streams with random TX byte time
      for (int r = 0; r < 3; r++) begin
         resp_delay = int'($urandom_range(2, 12));
         for (int p = 0; p < 25; p++) begin
            pulse(8'($urandom));
            repeat ($urandom_range(0, 3 * resp_delay + 4)) step();
         end
         wait_idle();
         compare_frames();
         chk("rand_timeout", got_timeout, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
